// File: rtl/ex_ctrl_pkg.sv
// ex_ctrl_pkg
// Shared definitions for the execute-stage control slice: opcode values,
// ALU operation encodings and the ID/EX control word carried down the
// pipeline.
//
// Contents:
//   RD_W          register-index width used inside the control word
//   OP_*          ID-stage opcode values (anything else is illegal)
//   alu_op_e      ALU operation driven to the execute stage
//   ctrl_word_t   decoded control word {valid, alu_op, alu_src, mr, mw,
//                 reg_write, rd}
//   CTRL_BUBBLE   the all-zero control word used for bubbles and reset
package ex_ctrl_pkg;

    localparam int RD_W = 3;

    localparam logic [3:0] OP_OR   = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_NOP  = 4'd7;

    // Register-register opcodes 0..3 map directly onto these encodings.
    typedef enum logic [1:0] {
        ALU_OR  = 2'b00,
        ALU_AND = 2'b01,
        ALU_XOR = 2'b10,
        ALU_ADD = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic            valid;
        alu_op_e         alu_op;
        logic            alu_src;
        logic            mr;
        logic            mw;
        logic            reg_write;
        logic [RD_W-1:0] rd;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/op_decode.sv
// op_decode
// Purely combinational opcode decoder for the ID stage. Produces the
// control word that would enter EX, plus which source registers the
// instruction actually reads (used by hazard detection and forwarding).
//
// Ports:
//   opcode     in   4     ID-stage opcode
//   rd         in   RD_W  ID-stage destination index
//   ctrl       out        decoded control word (bubble when illegal)
//   reads_rs1  out  1     instruction reads rs1
//   reads_rs2  out  1     instruction reads rs2 (ALU reg-reg ops and SW)
//   illegal    out  1     opcode is not defined
module op_decode
    import ex_ctrl_pkg::*;
(
    input  logic [3:0]      opcode,
    input  logic [RD_W-1:0] rd,
    output ctrl_word_t      ctrl,
    output logic            reads_rs1,
    output logic            reads_rs2,
    output logic            illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves one unassigned -- otherwise synthesis infers a latch.
        ctrl      = CTRL_BUBBLE;
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        illegal   = 1'b0;

        case (opcode)
            OP_OR, OP_AND, OP_XOR, OP_ADD: begin
                ctrl.valid     = 1'b1;
                ctrl.alu_op    = alu_op_e'(opcode[1:0]);
                ctrl.reg_write = 1'b1;
                ctrl.rd        = rd;
                reads_rs1      = 1'b1;
                reads_rs2      = 1'b1;
            end
            OP_ADDI: begin
                ctrl.valid     = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.rd        = rd;
                reads_rs1      = 1'b1;
            end
            OP_LW: begin
                ctrl.valid     = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mr        = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.rd        = rd;
                reads_rs1      = 1'b1;
            end
            OP_SW: begin
                // rs1 forms the address; rs2 is the store data.
                ctrl.valid     = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mw        = 1'b1;
                ctrl.rd        = rd;
                reads_rs1      = 1'b1;
                reads_rs2      = 1'b1;
            end
            OP_NOP: begin
                ctrl.valid     = 1'b1;
                ctrl.rd        = rd;
            end
            default: begin
                illegal        = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
// Execute-stage control and scheduling for the 5-stage pipeline. Decodes the
// ID instruction into the registered ID/EX control word, tracks destination
// registers through EX/MEM/WB, produces the EX/MEM-only forwarding selects
// and stalls ID for hazards forwarding cannot cover.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   id_valid          IF/ID holds a real instruction
//   id_opcode         ID opcode
//   id_rs1/rs2/rd     ID source/destination indices
//   flush             kill the ID instruction (branch redirect)
//   stall             hold PC and IF/ID (combinational)
//   ex_valid..ex_rd   registered ID/EX control word and forwarding selects
//   mem_reg_write/rd  EX/MEM write tracking
//   wb_reg_write/rd   MEM/WB write tracking
//   illegal_op        one-cycle pulse when an undefined opcode reaches EX
//   stall_count       saturating count of stall cycles
module ex_hazard_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [3:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [1:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_mw,
    output logic              ex_mr,
    output logic              ex_fa,
    output logic              ex_fb,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_reg_write,
    output logic [REG_AW-1:0] mem_rd,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  stall_count
);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    ctrl_word_t dec_ctrl;
    logic       dec_reads_rs1;
    logic       dec_reads_rs2;
    logic       dec_illegal;

    op_decode u_op_decode (
        .opcode    (id_opcode),
        .rd        (id_rd),
        .ctrl      (dec_ctrl),
        .reads_rs1 (dec_reads_rs1),
        .reads_rs2 (dec_reads_rs2),
        .illegal   (dec_illegal)
    );

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    ctrl_word_t        ex_q;
    logic              fa_q;
    logic              fb_q;
    logic              illegal_q;
    logic              mem_we_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic              wb_we_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    // ------------------------------------------------------------------
    // Hazard detection
    // The register file writes through, so WB is never a hazard. A load in
    // EX cannot be forwarded (its data appears in MEM), and forwarding only
    // comes from EX/MEM, so a writer already in MEM must wait one cycle for
    // the write-through. A load at distance 1 therefore stalls twice: once
    // as a load in EX, then again as a writer in MEM.
    // ------------------------------------------------------------------
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = (ex_q.valid && ex_q.mr && (ex_q.rd == id_rs1)) ||
                     (mem_we_q && (mem_rd_q == id_rs1));
    assign rs2_hit = (ex_q.valid && ex_q.mr && (ex_q.rd == id_rs2)) ||
                     (mem_we_q && (mem_rd_q == id_rs2));

    // flush dominates: a killed instruction has no operands to wait for.
    assign stall = id_valid && !flush &&
                   ((dec_reads_rs1 && rs1_hit) || (dec_reads_rs2 && rs2_hit));

    logic issue;
    assign issue = id_valid && !stall && !flush && !dec_illegal;

    // ------------------------------------------------------------------
    // Forwarding: decided at issue against the instruction currently in
    // EX, which will be in MEM when the issued instruction executes. Loads
    // are excluded; a dependent instruction behind a load never issues
    // while the load is in EX anyway.
    // ------------------------------------------------------------------
    logic fwd_src;
    logic fa_next;
    logic fb_next;

    assign fwd_src = ex_q.valid && ex_q.reg_write && !ex_q.mr;
    assign fa_next = issue && fwd_src && dec_reads_rs1 && (ex_q.rd == id_rs1);
    assign fb_next = issue && fwd_src && dec_reads_rs2 && (ex_q.rd == id_rs2);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= CTRL_BUBBLE;
            fa_q        <= 1'b0;
            fb_q        <= 1'b0;
            illegal_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_rd_q    <= '0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            // Downstream stages always advance; only ID can be held.
            wb_we_q  <= mem_we_q;
            wb_rd_q  <= mem_rd_q;
            mem_we_q <= ex_q.reg_write;
            mem_rd_q <= ex_q.rd;

            ex_q      <= issue ? dec_ctrl : CTRL_BUBBLE;
            fa_q      <= fa_next;
            fb_q      <= fb_next;
            illegal_q <= id_valid && !flush && !stall && dec_illegal;

            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ex_valid      = ex_q.valid;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mw         = ex_q.mw;
    assign ex_mr         = ex_q.mr;
    assign ex_rd         = ex_q.rd;
    assign ex_fa         = fa_q;
    assign ex_fb         = fb_q;
    assign mem_reg_write = mem_we_q;
    assign mem_rd        = mem_rd_q;
    assign wb_reg_write  = wb_we_q;
    assign wb_rd         = wb_rd_q;
    assign illegal_op    = illegal_q;
    assign stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: a table of per-cycle vectors with
// hand-computed expectations, followed by directed sequences for counter
// saturation and reset in the middle of a stall.
module tb_ex_hazard_ctrl;

    localparam int REG_AW = 3;
    localparam int CNT_W  = 4;   // small so saturation is reachable quickly

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [3:0]        id_opcode;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              flush;
    logic              stall;
    logic              ex_valid;
    logic [1:0]        ex_alu_op;
    logic              ex_alu_src;
    logic              ex_mw;
    logic              ex_mr;
    logic              ex_fa;
    logic              ex_fb;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic              illegal_op;
    logic [CNT_W-1:0]  stall_count;

    ex_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .flush         (flush),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_alu_op     (ex_alu_op),
        .ex_alu_src    (ex_alu_src),
        .ex_mw         (ex_mw),
        .ex_mr         (ex_mr),
        .ex_fa         (ex_fa),
        .ex_fb         (ex_fb),
        .ex_rd         (ex_rd),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .illegal_op    (illegal_op),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One row = the ID inputs for one cycle, the expected combinational
    // stall during that cycle, and the EX contents expected after the edge.
    typedef struct {
        logic       v;
        logic [3:0] op;
        logic [2:0] rs1, rs2, rd;
        logic       fl;
        logic       e_stall;
        logic       e_ev;
        logic [1:0] e_aop;
        logic       e_src, e_mr, e_mw, e_fa, e_fb;
        logic [2:0] e_rd;
        logic       e_ill;
        logic       e_we;
    } vec_t;

    function automatic vec_t mk(
        input logic v, input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
        input logic [2:0] rd, input logic fl, input logic st,
        input logic ev, input logic [1:0] aop, input logic src, input logic mr, input logic mw,
        input logic fa, input logic fb, input logic [2:0] erd, input logic ill, input logic we);
        vec_t r;
        r.v = v; r.op = op; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.fl = fl;
        r.e_stall = st; r.e_ev = ev; r.e_aop = aop; r.e_src = src; r.e_mr = mr;
        r.e_mw = mw; r.e_fa = fa; r.e_fb = fb; r.e_rd = erd; r.e_ill = ill; r.e_we = we;
        return r;
    endfunction

    function automatic vec_t idle();
        return mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t bub(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                                 input logic [2:0] rd, input logic fl, input logic st);
        return mk(1, op, rs1, rs2, rd, fl, st, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [2:0] rd, input logic fl);
        id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; flush = fl;
    endtask

    vec_t vecs[26];
    int   exp_cnt;
    logic exp_mem_we, exp_wb_we;
    logic [2:0] exp_mem_rd, exp_wb_rd;

    initial begin
        //                v  op  rs1 rs2 rd fl st  ev aop src mr mw fa fb erd ill we
        // ADD r1,r2,r3 ; XOR r4,r1,r5 -> forward rs1, no stall
        vecs[0]  = mk(1, 4'd3, 2, 3, 1, 0, 0,  1, 2'd3, 0, 0, 0, 0, 0, 1, 0, 1);
        vecs[1]  = mk(1, 4'd2, 1, 5, 4, 0, 0,  1, 2'd2, 0, 0, 0, 1, 0, 4, 0, 1);
        vecs[2]  = idle();
        // LW r1 ; ADD r2,r1,r1 -> two stall cycles, no forwarding
        vecs[3]  = mk(1, 4'd5, 0, 0, 1, 0, 0,  1, 2'd3, 1, 1, 0, 0, 0, 1, 0, 1);
        vecs[4]  = bub(4'd3, 1, 1, 2, 0, 1);
        vecs[5]  = bub(4'd3, 1, 1, 2, 0, 1);
        vecs[6]  = mk(1, 4'd3, 1, 1, 2, 0, 0,  1, 2'd3, 0, 0, 0, 0, 0, 2, 0, 1);
        vecs[7]  = idle();
        // ADD r1 ; NOP ; SW rs2=r1 -> one stall on store data
        vecs[8]  = mk(1, 4'd3, 4, 5, 1, 0, 0,  1, 2'd3, 0, 0, 0, 0, 0, 1, 0, 1);
        vecs[9]  = mk(1, 4'd7, 0, 0, 0, 0, 0,  1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[10] = bub(4'd6, 0, 1, 0, 0, 1);
        vecs[11] = mk(1, 4'd6, 0, 1, 0, 0, 0,  1, 2'd3, 1, 0, 1, 0, 0, 0, 0, 0);
        vecs[12] = idle();
        // ADD r3 ; SW rs1=r0 rs2=r3 -> store data forwarded
        vecs[13] = mk(1, 4'd3, 4, 5, 3, 0, 0,  1, 2'd3, 0, 0, 0, 0, 0, 3, 0, 1);
        vecs[14] = mk(1, 4'd6, 0, 3, 0, 0, 0,  1, 2'd3, 1, 0, 1, 0, 1, 0, 0, 0);
        // ADDI with rs2 matching MEM writer -> no stall (rs2 not read)
        vecs[15] = mk(1, 4'd4, 7, 3, 5, 0, 0,  1, 2'd3, 1, 0, 0, 0, 0, 5, 0, 1);
        // AND r6,r5,r5 after ADDI r5 -> both selects forward
        vecs[16] = mk(1, 4'd1, 5, 5, 6, 0, 0,  1, 2'd1, 0, 0, 0, 1, 1, 6, 0, 1);
        // ADDI r1 with rs2=r6 matching EX writer -> fb stays 0
        vecs[17] = mk(1, 4'd4, 0, 6, 1, 0, 0,  1, 2'd3, 1, 0, 0, 0, 0, 1, 0, 1);
        vecs[18] = idle();
        vecs[19] = idle();
        // Illegal opcode 4'hC -> bubble with a single illegal_op pulse
        vecs[20] = mk(1, 4'hC, 1, 1, 2, 0, 0,  0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[21] = idle();
        // LW r2 ; ADD r3,r2 stalls ; flush during the stall wins
        vecs[22] = mk(1, 4'd5, 0, 0, 2, 0, 0,  1, 2'd3, 1, 1, 0, 0, 0, 2, 0, 1);
        vecs[23] = bub(4'd3, 2, 0, 3, 0, 1);
        vecs[24] = bub(4'd3, 2, 0, 3, 1, 0);
        vecs[25] = idle();

        // Reset state
        rst_n = 1'b0;
        drive(0, 4'd0, 0, 0, 0, 0);
        #3;
        check("reset_state",
              {stall, ex_valid, ex_alu_op, ex_alu_src, ex_mr, ex_mw, ex_fa, ex_fb, ex_rd,
               mem_reg_write, mem_rd, wb_reg_write, wb_rd, illegal_op, stall_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        exp_cnt = 0;
        exp_mem_we = 0; exp_mem_rd = 0; exp_wb_we = 0; exp_wb_rd = 0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].fl);
            #1;
            check($sformatf("row%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
            @(posedge clk);
            #1;
            if (vecs[i].e_stall) exp_cnt++;
            exp_wb_we  = exp_mem_we;
            exp_wb_rd  = exp_mem_rd;
            if (i > 0) begin
                exp_mem_we = vecs[i-1].e_we;
                exp_mem_rd = vecs[i-1].e_rd;
            end
            check($sformatf("row%0d ex_word", i),
                  {20'd0, ex_valid, ex_alu_op, ex_alu_src, ex_mr, ex_mw, ex_fa, ex_fb, ex_rd, illegal_op},
                  {20'd0, vecs[i].e_ev, vecs[i].e_aop, vecs[i].e_src, vecs[i].e_mr, vecs[i].e_mw,
                   vecs[i].e_fa, vecs[i].e_fb, vecs[i].e_rd, vecs[i].e_ill});
            check($sformatf("row%0d mem_wb", i),
                  {24'd0, mem_reg_write, mem_rd, wb_reg_write, wb_rd},
                  {24'd0, exp_mem_we, exp_mem_rd, exp_wb_we, exp_wb_rd});
            check($sformatf("row%0d stall_count", i), 32'(stall_count), 32'(exp_cnt));
        end

        // Saturation: repeated LW / dependent ADD pairs, two stalls each.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(1, 4'd5, 0, 0, 1, 0);
            @(posedge clk);
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                drive(1, 4'd3, 1, 1, 2, 0);
                #1;
                check($sformatf("sat%0d stall%0d", k, j), {31'd0, stall}, {31'd0, (j < 2)});
                @(posedge clk);
            end
            #1;
            exp_cnt = (exp_cnt + 2 > 15) ? 15 : exp_cnt + 2;
            check($sformatf("sat%0d stall_count", k), 32'(stall_count), 32'(exp_cnt));
        end

        // Reset in the middle of a load-use stall.
        @(negedge clk);
        drive(0, 4'd0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 4'd5, 0, 0, 1, 0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 4'd3, 1, 1, 2, 0);
        #1;
        check("midstall stall_before_reset", {31'd0, stall}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midstall outputs_zero",
              {stall, ex_valid, ex_alu_op, ex_alu_src, ex_mr, ex_mw, ex_fa, ex_fb, ex_rd,
               mem_reg_write, mem_rd, wb_reg_write, wb_rd, illegal_op, stall_count}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 4'd4, 1, 0, 1, 0);   // ADDI r1, r1
        #1;
        check("post_reset stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        check("post_reset ex_word",
              {22'd0, ex_valid, ex_alu_op, ex_alu_src, ex_mr, ex_mw, ex_fa, ex_fb, ex_rd},
              {22'd0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1});
        check("post_reset stall_count", 32'(stall_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
